// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Purpose
//   Turns the raw LaunchPad push-button pin into clean, single-clock events for
//   the LED event stages. The pin is first brought into the CLK domain with a
//   two-flop synchroniser. A four-state debounce FSM then accepts a level
//   change only after DEBOUNCE_CYCLES consecutive stable synchronised samples.
//   From the accepted level the block derives edge pulses and a wrapping
//   press counter.
//
// Parameters
//   DEBOUNCE_CYCLES  stable synced samples needed to accept a change (>= 2)
//   LONG_CYCLES      cycles held in PRESSED before btn_long fires (>= 1)
//   CNT_W            width of press_count
//
// Ports
//   CLK          in   1      system clock, every register on the rising edge
//   RST          in   1      synchronous, active-high reset
//   button_raw   in   1      asynchronous raw button pin, active-high
//   btn_level    out  1      debounced level, 1 = pressed
//   btn_press    out  1      one-cycle pulse on an accepted press
//   btn_release  out  1      one-cycle pulse on an accepted release
//   press_count  out  CNT_W  accepted presses, wraps modulo 2^CNT_W
//   btn_long     out  1      one-cycle long-press pulse
//
// Configuration
//   BTN_LONG_PRESS_EN  when defined, a hold counter is built and btn_long
//                      pulses once per accepted press after LONG_CYCLES
//                      cycles held. When undefined, btn_long is tied to 0.
//
// Timing
//   If button_raw is high from sampling edge E onward, the FSM reaches PRESSED
//   on edge E+DEBOUNCE_CYCLES+1. btn_level and btn_press rise on edge
//   E+DEBOUNCE_CYCLES+2. Releases follow the same timing.
// -----------------------------------------------------------------------------
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LONG_CYCLES     = 64,
  parameter int CNT_W           = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             button_raw,
  output logic             btn_level,
  output logic             btn_press,
  output logic             btn_release,
  output logic [CNT_W-1:0] press_count,
  output logic             btn_long
);

  // Debounce counter width. It only has to reach DEBOUNCE_CYCLES-1.
  localparam int DBC_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DBC_W-1:0] DBC_LAST = DBC_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,  // level 0, input stable low
    PRESS_WAIT   = 2'd1,  // level 0, input high, counting toward accept
    PRESSED      = 2'd2,  // level 1, input stable high
    RELEASE_WAIT = 2'd3   // level 1, input low, counting toward accept
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers and their next-state values
  // ---------------------------------------------------------------------------
  logic             sync1;
  logic             sync2;
  state_t           state;
  state_t           state_next;
  logic [DBC_W-1:0] dbc;
  logic [DBC_W-1:0] dbc_next;

  // The entry flags record which transition just happened. They let the
  // registered outputs pulse on the first cycle of the new state, which keeps
  // btn_press aligned with btn_level.
  logic             press_entry;
  logic             press_entry_next;
  logic             release_entry;
  logic             release_entry_next;

  // Output register inputs
  logic             level_d;
  logic             press_d;
  logic             release_d;
  logic [CNT_W-1:0] count_d;
  logic             long_d;

`ifdef BTN_LONG_PRESS_EN
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);

  logic [HOLD_W-1:0] hold;
  logic [HOLD_W-1:0] hold_next;
  logic              long_hit;
  logic              long_hit_next;
`endif

  // ---------------------------------------------------------------------------
  // Process 1: state register. This also holds the synchroniser and the
  // output registers.
  // ---------------------------------------------------------------------------
  // NOTE: every flop here uses <=, so all right-hand sides read the values from
  // before the edge. The synchroniser chain depends on this: sync2 takes the
  // old sync1, not the value sync1 is receiving on the same edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1         <= 1'b0;
      sync2         <= 1'b0;
      state         <= IDLE;
      dbc           <= '0;
      press_entry   <= 1'b0;
      release_entry <= 1'b0;
      btn_level     <= 1'b0;
      btn_press     <= 1'b0;
      btn_release   <= 1'b0;
      press_count   <= '0;
      btn_long      <= 1'b0;
    end else begin
      sync1         <= button_raw;
      sync2         <= sync1;
      state         <= state_next;
      dbc           <= dbc_next;
      press_entry   <= press_entry_next;
      release_entry <= release_entry_next;
      btn_level     <= level_d;
      btn_press     <= press_d;
      btn_release   <= release_d;
      press_count   <= count_d;
      btn_long      <= long_d;
    end
  end

`ifdef BTN_LONG_PRESS_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      hold     <= '0;
      long_hit <= 1'b0;
    end else begin
      hold     <= hold_next;
      long_hit <= long_hit_next;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Process 2: next-state logic. The FSM reads only sync2.
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets a default at the top of the block. Without the
  // defaults, any branch that skipped an assignment would infer a latch.
  always_comb begin
    state_next = state;
    dbc_next   = dbc;

    unique case (state)
      IDLE: begin
        if (sync2) begin
          state_next = PRESS_WAIT;
          dbc_next   = DBC_W'(1);
        end
      end

      PRESS_WAIT: begin
        if (!sync2) begin
          state_next = IDLE;
          dbc_next   = '0;
        end else if (dbc == DBC_LAST) begin
          state_next = PRESSED;
          dbc_next   = '0;
        end else begin
          dbc_next   = dbc + DBC_W'(1);
        end
      end

      PRESSED: begin
        if (!sync2) begin
          state_next = RELEASE_WAIT;
          dbc_next   = DBC_W'(1);
        end
      end

      RELEASE_WAIT: begin
        if (sync2) begin
          // Bounce during release: go back to PRESSED with no new press event.
          state_next = PRESSED;
          dbc_next   = '0;
        end else if (dbc == DBC_LAST) begin
          state_next = IDLE;
          dbc_next   = '0;
        end else begin
          dbc_next   = dbc + DBC_W'(1);
        end
      end

      default: begin
        state_next = IDLE;
        dbc_next   = '0;
      end
    endcase

    press_entry_next   = (state == PRESS_WAIT)   && (state_next == PRESSED);
    release_entry_next = (state == RELEASE_WAIT) && (state_next == IDLE);
  end

`ifdef BTN_LONG_PRESS_EN
  // The hold counter runs while the debounced level is 1. It saturates at
  // LONG_CYCLES, so btn_long can fire only once per accepted press. Bounces
  // through RELEASE_WAIT do not restart it.
  always_comb begin
    hold_next = hold;
    if ((state == PRESSED || state == RELEASE_WAIT) && (hold != HOLD_MAX)) begin
      hold_next = hold + HOLD_W'(1);
    end
    if ((state_next == IDLE) ||
        (state == PRESS_WAIT && state_next == PRESSED)) begin
      hold_next = '0;
    end
    long_hit_next = (hold_next == HOLD_MAX) && (hold != HOLD_MAX);
  end
`endif

  // ---------------------------------------------------------------------------
  // Process 3: output logic. These values feed the output registers, so every
  // output appears one edge after the state that produces it.
  // ---------------------------------------------------------------------------
  always_comb begin
    level_d   = (state == PRESSED) || (state == RELEASE_WAIT);
    press_d   = press_entry;
    release_d = release_entry;
    // The counter steps on the same edge that raises btn_press.
    count_d   = press_entry ? press_count + CNT_W'(1) : press_count;
`ifdef BTN_LONG_PRESS_EN
    long_d    = long_hit;
`else
    long_d    = 1'b0;
`endif
  end

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
//
// Self-checking bench for button_conditioner, with DEBOUNCE_CYCLES=4,
// LONG_CYCLES=8 and CNT_W=8.
//
// Each stimulus task pushes the pulse events it expects onto exp_q. Each event
// records its kind, the cycle it should appear on and the expected
// press_count. A monitor process samples on the falling edge. It pops and
// compares an entry for every pulse the DUT raises. The tasks also check
// btn_level and press_count inline.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

  localparam int DEB   = 4;
  localparam int LONGC = 8;
  localparam int CW    = 8;
  // A press accepted from sampling edge E shows up after edge E+DEB+2. Inputs
  // change at the falling edge while cyc=c, so E=c+1 and the pulse appears
  // when cyc = c+DEB+3.
  localparam int LAT   = DEB + 3;

  localparam int K_PRESS   = 0;
  localparam int K_RELEASE = 1;
  localparam int K_LONG    = 2;

  logic          CLK;
  logic          RST;
  logic          button_raw;
  logic          btn_level;
  logic          btn_press;
  logic          btn_release;
  logic [CW-1:0] press_count;
  logic          btn_long;

  button_conditioner #(
    .DEBOUNCE_CYCLES (DEB),
    .LONG_CYCLES     (LONGC),
    .CNT_W           (CW)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .button_raw  (button_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .press_count (press_count),
    .btn_long    (btn_long)
  );

  typedef struct {
    int kind;
    int cycle;
    int count;
  } exp_t;

  exp_t exp_q[$];
  int   errors      = 0;
  int   checks      = 0;
  int   cyc         = 0;
  int   n_press     = 0;
  int   model_count = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Scoreboard monitor: each pulse the DUT raises must match the oldest
  // expected event.
  always @(negedge CLK) begin
    logic [2:0] pulses;
    pulses = {btn_long === 1'b1, btn_release === 1'b1, btn_press === 1'b1};
    if (pulses[K_PRESS] && pulses[K_RELEASE]) begin
      errors++;
      $display("FAIL press_release_overlap: both pulses high at cycle %0d, required at most one", cyc);
    end
    for (int k = 0; k < 3; k++) begin
      if (pulses[k]) begin
        exp_t e;
        checks++;
        if (k == K_PRESS) n_press++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: kind %0d at cycle %0d, required no pulse", k, cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.kind !== k || e.cycle !== cyc || e.count !== int'(press_count)) begin
            errors++;
            $display("FAIL pulse_event: got kind %0d cycle %0d count %0d, required kind %0d cycle %0d count %0d",
                     k, cyc, press_count, e.kind, e.cycle, e.count);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic push_exp(input int kind, input int cycle, input int count);
    exp_t e;
    e.kind  = kind;
    e.cycle = cycle;
    e.count = count;
    exp_q.push_back(e);
  endtask

  // Clean press held for 'hold' cycles, followed by a clean release.
  task automatic press_and_release(input int hold);
    int c;
    c = cyc;
    button_raw  = 1'b1;
    model_count = (model_count + 1) % (1 << CW);
    push_exp(K_PRESS, c + LAT, model_count);
`ifdef BTN_LONG_PRESS_EN
    if (hold >= LONGC + 1) push_exp(K_LONG, c + LAT + LONGC, model_count);
`endif
    tick(hold);
    c = cyc;
    button_raw = 1'b0;
    push_exp(K_RELEASE, c + LAT, model_count);
    tick(LAT + 1);
  endtask

  task automatic test_reset();
    int c;
    // Reset is high for two edges while the button is already held.
    RST = 1'b1;
    button_raw = 1'b1;
    tick(2);
    checks++;
    if ({btn_level, btn_press, btn_release, btn_long} !== 4'b0 || press_count !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got level/press/release/long=%b count=%0d, required 0000 count=0",
               {btn_level, btn_press, btn_release, btn_long}, press_count);
    end
    RST = 1'b0;
    c = cyc;
    model_count = 1;
    push_exp(K_PRESS, c + LAT, 1);
    tick(LAT + 1);
    checks++;
    if (btn_level !== 1'b1 || press_count !== 8'd1) begin
      errors++;
      $display("FAIL reset_first_press: got level=%b count=%0d, required level=1 count=1", btn_level, press_count);
    end
    // Reset again while still pressed. The press must be found again from IDLE.
    RST = 1'b1;
    tick(2);
    checks++;
    if (btn_level !== 1'b0 || press_count !== '0) begin
      errors++;
      $display("FAIL reset_midop: got level=%b count=%0d, required level=0 count=0", btn_level, press_count);
    end
    RST = 1'b0;
    c = cyc;
    model_count = 1;
    push_exp(K_PRESS, c + LAT, 1);
    tick(4);
    c = cyc;
    button_raw = 1'b0;
    push_exp(K_RELEASE, c + LAT, 1);
    tick(LAT + 2);
    checks++;
    if (exp_q.size() != 0 || press_count !== 8'd1) begin
      errors++;
      $display("FAIL reset_repress: got pending=%0d count=%0d, required pending=0 count=1", exp_q.size(), press_count);
    end
  endtask

  task automatic test_clean_press();
    int c;
    c = cyc;
    button_raw  = 1'b1;
    model_count = (model_count + 1) % (1 << CW);
    push_exp(K_PRESS, c + LAT, model_count);
    tick(LAT - 1);
    checks++;
    if (btn_level !== 1'b0) begin
      errors++;
      $display("FAIL press_early: got level=%b, required 0 one cycle before accept", btn_level);
    end
    tick(1);
    checks++;
    if (btn_level !== 1'b1 || btn_press !== 1'b1 || press_count !== CW'(model_count)) begin
      errors++;
      $display("FAIL press_accept: got level=%b press=%b count=%0d, required 1 1 %0d",
               btn_level, btn_press, press_count, model_count);
    end
    tick(1);
    checks++;
    if (btn_press !== 1'b0 || btn_level !== 1'b1) begin
      errors++;
      $display("FAIL press_single: got press=%b level=%b, required press=0 level=1", btn_press, btn_level);
    end
    tick(4);
    c = cyc;
    button_raw = 1'b0;
    push_exp(K_RELEASE, c + LAT, model_count);
    tick(LAT - 1);
    checks++;
    if (btn_level !== 1'b1) begin
      errors++;
      $display("FAIL release_early: got level=%b, required 1", btn_level);
    end
    tick(1);
    checks++;
    if (btn_level !== 1'b0 || btn_release !== 1'b1) begin
      errors++;
      $display("FAIL release_accept: got level=%b release=%b, required 0 1", btn_level, btn_release);
    end
    tick(2);
  endtask

  task automatic test_bounce();
    logic [5:0] pattern;
    pattern = 6'b011011;  // applied LSB first: 1,1,0,1,1,0
    for (int i = 0; i < 6; i++) begin
      button_raw = pattern[i];
      tick(1);
    end
    tick(12);
    checks++;
    if (btn_level !== 1'b0 || press_count !== CW'(model_count) || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bounce_ignored: got level=%b count=%0d pending=%0d, required 0 %0d 0",
               btn_level, press_count, exp_q.size(), model_count);
    end
  endtask

  task automatic test_release_bounce();
    int c;
    c = cyc;
    button_raw  = 1'b1;
    model_count = (model_count + 1) % (1 << CW);
    push_exp(K_PRESS, c + LAT, model_count);
    tick(LAT + 3);
    checks++;
    if (btn_level !== 1'b1) begin
      errors++;
      $display("FAIL rb_pressed: got level=%b, required 1", btn_level);
    end
    button_raw = 1'b0;
    tick(2);
    button_raw = 1'b1;
    tick(1);
    c = cyc;
    button_raw = 1'b0;
    push_exp(K_RELEASE, c + LAT, model_count);
    tick(LAT - 1);
    checks++;
    if (btn_level !== 1'b1) begin
      errors++;
      $display("FAIL rb_hold_level: got level=%b, required 1 before final accept", btn_level);
    end
    tick(1);
    checks++;
    if (btn_level !== 1'b0 || btn_release !== 1'b1) begin
      errors++;
      $display("FAIL rb_release: got level=%b release=%b, required 0 1", btn_level, btn_release);
    end
    tick(3);
  endtask

  task automatic test_long_press();
    int   c;
    logic exp_long;
`ifdef BTN_LONG_PRESS_EN
    exp_long = 1'b1;
`else
    exp_long = 1'b0;
`endif
    c = cyc;
    button_raw  = 1'b1;
    model_count = (model_count + 1) % (1 << CW);
    push_exp(K_PRESS, c + LAT, model_count);
`ifdef BTN_LONG_PRESS_EN
    push_exp(K_LONG, c + LAT + LONGC, model_count);
`endif
    tick(LAT + LONGC);
    checks++;
    if (btn_long !== exp_long) begin
      errors++;
      $display("FAIL long_pulse: got btn_long=%b, required %b", btn_long, exp_long);
    end
    tick(1);
    checks++;
    if (btn_long !== 1'b0) begin
      errors++;
      $display("FAIL long_once: got btn_long=%b, required 0", btn_long);
    end
    tick(20 - LAT - LONGC - 1);
    c = cyc;
    button_raw = 1'b0;
    push_exp(K_RELEASE, c + LAT, model_count);
    tick(LAT + 2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL long_events: got %0d pending events, required 0", exp_q.size());
    end
  endtask

  task automatic test_wrap();
    int n0;
    RST = 1'b1;
    button_raw = 1'b0;
    tick(2);
    RST = 1'b0;
    model_count = 0;
    n0 = n_press;
    for (int i = 0; i < 256; i++) press_and_release(6);
    checks++;
    if (press_count !== '0 || (n_press - n0) != 256 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL wrap: got count=%0d presses=%0d pending=%0d, required 0 256 0",
               press_count, n_press - n0, exp_q.size());
    end
  endtask

  initial begin
    RST = 1'b1;
    button_raw = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_bounce();
    test_long_press();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
